// File: rtl/quad_decoder_pkg.sv
// Shared types and Gray-phase helpers for the quadrature decoder.
// qstep classifies one phase transition by its distance around the Gray cycle.
package quad_pkg;

  typedef enum logic {INIT, RUN} state_t;

  typedef enum logic [1:0] {NONE, STEP_CW, STEP_CCW, ILLEGAL} step_t;

  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_10 = 2'b10;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_01 = 2'b01;

  // Position of a phase along the clockwise cycle 00 -> 10 -> 11 -> 01.
  function automatic logic [1:0] ph_idx(input logic [1:0] ph);
    case (ph)
      PH_00:   ph_idx = 2'd0;
      PH_10:   ph_idx = 2'd1;
      PH_11:   ph_idx = 2'd2;
      default: ph_idx = 2'd3;
    endcase
  endfunction

  function automatic step_t qstep(input logic [1:0] prev, input logic [1:0] cur);
    logic [1:0] d;
    d = ph_idx(cur) - ph_idx(prev);
    case (d)
      2'd0:    qstep = NONE;
      2'd1:    qstep = STEP_CW;
      2'd3:    qstep = STEP_CCW;
      default: qstep = ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// Two-flop synchronizer followed by a stability counter for one encoder channel.
// load forces the debounced value to the synchronized value (used once after reset).
module debounce_bit
  import quad_pkg::*;
#(
  parameter int DEB_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic d_async,
  input  logic load,
  output logic sync,
  output logic q
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_deb;
  logic [CNT_W-1:0] r_dcnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_deb   <= 1'b0;
      r_dcnt  <= '0;
    end else begin
      r_sync1 <= d_async;
      r_sync2 <= r_sync1;
      if (load) begin
        r_deb  <= r_sync2;
        r_dcnt <= '0;
      end else if (r_sync2 != r_deb) begin
        if (r_dcnt == CNT_LAST) begin
          r_deb  <= r_sync2;
          r_dcnt <= '0;
        end else begin
          r_dcnt <= r_dcnt + CNT_W'(1);
        end
      end else begin
        r_dcnt <= '0;
      end
    end
  end

  assign sync = r_sync2;
  assign q    = r_deb;

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder: debounced A/B phase tracking, signed detent accumulator,
// one-cycle en step pulses with cw direction, and a sticky illegal-transition flag.
module quad_decoder
  import quad_pkg::*;
#(
  parameter int DEB_CYCLES = 1000,
  parameter int DIV        = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic a_in,
  input  logic b_in,
  input  logic clr_err,
  output logic en,
  output logic cw,
  output logic err
);

  localparam logic signed [3:0] DIV_S = 4'(DIV);

  logic w_sync_a, w_sync_b;
  logic w_deb_a, w_deb_b;
  logic w_load;

  state_t            r_state, w_state_nxt;
  logic [1:0]        r_init_cnt, w_init_cnt_nxt;
  logic [1:0]        r_phase, w_phase_nxt;
  logic signed [3:0] r_acc, w_acc_nxt, w_acc_t;
  logic              r_en, w_en_nxt;
  logic              r_cw, w_cw_nxt;
  logic              r_err, w_err_nxt;
  logic              w_err_set;
  step_t             w_step;

  // Synchronizers take two cycles to fill; the phase is loaded on the third.
  assign w_load = (r_state == INIT) && (r_init_cnt == 2'd2);

  debounce_bit #(.DEB_CYCLES(DEB_CYCLES)) u_deb_a (
    .clk     (clk),
    .rst     (rst),
    .d_async (a_in),
    .load    (w_load),
    .sync    (w_sync_a),
    .q       (w_deb_a)
  );

  debounce_bit #(.DEB_CYCLES(DEB_CYCLES)) u_deb_b (
    .clk     (clk),
    .rst     (rst),
    .d_async (b_in),
    .load    (w_load),
    .sync    (w_sync_b),
    .q       (w_deb_b)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= INIT;
      r_init_cnt <= 2'd0;
      r_phase    <= PH_00;
      r_acc      <= '0;
      r_en       <= 1'b0;
      r_cw       <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_init_cnt <= w_init_cnt_nxt;
      r_phase    <= w_phase_nxt;
      r_acc      <= w_acc_nxt;
      r_en       <= w_en_nxt;
      r_cw       <= w_cw_nxt;
      r_err      <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_init_cnt_nxt = r_init_cnt;
    w_phase_nxt    = r_phase;
    w_acc_nxt      = r_acc;
    w_acc_t        = r_acc;
    w_en_nxt       = 1'b0;
    w_cw_nxt       = r_cw;
    w_err_set      = 1'b0;
    w_step         = qstep(r_phase, {w_deb_a, w_deb_b});

    case (r_state)
      INIT: begin
        w_acc_nxt = '0;
        if (w_load) begin
          w_phase_nxt = {w_sync_a, w_sync_b};
          w_state_nxt = RUN;
        end else begin
          w_init_cnt_nxt = r_init_cnt + 2'd1;
        end
      end
      default: begin
        w_phase_nxt = {w_deb_a, w_deb_b};
        case (w_step)
          STEP_CW:  w_acc_t = r_acc + 4'sd1;
          STEP_CCW: w_acc_t = r_acc - 4'sd1;
          ILLEGAL: begin
            w_err_set = 1'b1;
            w_acc_t   = '0;
          end
          default:  w_acc_t = r_acc;
        endcase
        // A full detent in either direction emits a step and restarts the count.
        if (w_acc_t == DIV_S) begin
          w_en_nxt  = 1'b1;
          w_cw_nxt  = 1'b1;
          w_acc_nxt = '0;
        end else if (w_acc_t == -DIV_S) begin
          w_en_nxt  = 1'b1;
          w_cw_nxt  = 1'b0;
          w_acc_nxt = '0;
        end else begin
          w_acc_nxt = w_acc_t;
        end
      end
    endcase

    w_err_nxt = w_err_set | (r_err & ~clr_err);
  end

  assign en  = r_en;
  assign cw  = r_cw;
  assign err = r_err;

endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder with DEB_CYCLES=4: one instance at DIV=1 and
// one at DIV=4 share the same encoder inputs.
module tb_quad_decoder;

  logic clk = 1'b0;
  logic rst;
  logic a_in, b_in, clr_err;
  logic en1, cw1, err1;
  logic en4, cw4, err4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  quad_decoder #(.DEB_CYCLES(4), .DIV(1)) u_dut1 (
    .clk     (clk),
    .rst     (rst),
    .a_in    (a_in),
    .b_in    (b_in),
    .clr_err (clr_err),
    .en      (en1),
    .cw      (cw1),
    .err     (err1)
  );

  quad_decoder #(.DEB_CYCLES(4), .DIV(4)) u_dut4 (
    .clk     (clk),
    .rst     (rst),
    .a_in    (a_in),
    .b_in    (b_in),
    .clr_err (clr_err),
    .en      (en4),
    .cw      (cw4),
    .err     (err4)
  );

  typedef struct {
    logic a;
    logic b;
    int   n1;
    logic cw1;
    int   n4;
    logic cw4;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Runs n cycles, sampling 1 time unit after each rising edge.
  task automatic run(input int n, output int c1, output int c4, output int f1);
    c1 = 0;
    c4 = 0;
    f1 = -1;
    for (int k = 1; k <= n; k++) begin
      @(posedge clk);
      #1;
      if (en1) begin
        c1++;
        if (f1 < 0) f1 = k;
      end
      if (en4) c4++;
    end
  endtask

  task automatic do_reset(input logic a, input logic b);
    int c1, c4, f1;
    a_in = a;
    b_in = b;
    rst  = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    run(12, c1, c4, f1);
    chk("settle_en1", c1, 0);
    chk("settle_en4", c4, 0);
  endtask

  initial begin
    int c1, c4, f1, t1, t4;

    tbl[0]  = '{1'b1, 1'b0, 1, 1'b1, 0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1, 1'b1, 0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1, 1'b1, 0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1, 1'b1, 1, 1'b1};
    tbl[4]  = '{1'b0, 1'b1, 1, 1'b0, 0, 1'b1};
    tbl[5]  = '{1'b1, 1'b1, 1, 1'b0, 0, 1'b1};
    tbl[6]  = '{1'b1, 1'b0, 1, 1'b0, 0, 1'b1};
    tbl[7]  = '{1'b0, 1'b0, 1, 1'b0, 1, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 1, 1'b1, 0, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1, 1'b0, 0, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1, 1'b0, 0, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 1, 1'b1, 0, 1'b0};

    rst     = 1'b1;
    a_in    = 1'b1;
    b_in    = 1'b1;
    clr_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_en1", int'(en1), 0);
    chk("rst_cw1", int'(cw1), 0);
    chk("rst_err1", int'(err1), 0);
    chk("rst_en4", int'(en4), 0);

    // Inputs held at 11 through reset release: INIT loads 11 silently.
    rst = 1'b0;
    run(20, c1, c4, f1);
    chk("init11_en1", c1, 0);
    chk("init11_en4", c4, 0);
    chk("init11_err1", int'(err1), 0);
    a_in = 1'b0;
    run(10, c1, c4, f1);
    chk("init11_step_n1", c1, 1);
    chk("init11_step_cw1", int'(cw1), 1);
    chk("init11_step_err1", int'(err1), 0);

    do_reset(1'b0, 1'b0);

    for (int i = 0; i < 12; i++) begin
      a_in = tbl[i].a;
      b_in = tbl[i].b;
      run(10, c1, c4, f1);
      chk($sformatf("vec%0d_n1", i), c1, tbl[i].n1);
      chk($sformatf("vec%0d_cw1", i), int'(cw1), int'(tbl[i].cw1));
      chk($sformatf("vec%0d_n4", i), c4, tbl[i].n4);
      chk($sformatf("vec%0d_cw4", i), int'(cw4), int'(tbl[i].cw4));
      chk($sformatf("vec%0d_err1", i), int'(err1), 0);
      if (i == 0) chk("first_latency", f1, 7);
    end

    // Glitch of 2 cycles is rejected; a 10-cycle hold produces one step.
    a_in = 1'b1;
    run(2, c1, c4, f1);
    t1 = c1;
    a_in = 1'b0;
    run(10, c1, c4, f1);
    chk("glitch_n1", t1 + c1, 0);
    a_in = 1'b1;
    run(10, c1, c4, f1);
    chk("glitch_hold_n1", c1, 1);
    chk("glitch_hold_cw1", int'(cw1), 1);

    // Illegal two-bit change, sticky err and clear.
    do_reset(1'b0, 1'b0);
    a_in = 1'b1;
    b_in = 1'b1;
    run(10, c1, c4, f1);
    chk("illegal_n1", c1, 0);
    chk("illegal_n4", c4, 0);
    chk("illegal_err1", int'(err1), 1);
    chk("illegal_err4", int'(err4), 1);
    run(5, c1, c4, f1);
    chk("err_sticky", int'(err1), 1);
    clr_err = 1'b1;
    @(posedge clk);
    #1 clr_err = 1'b0;
    chk("err_cleared", int'(err1), 0);

    // Set coincides with clr_err: the deb update lands on edge 6, err sets on edge 7.
    a_in = 1'b0;
    b_in = 1'b0;
    run(6, c1, c4, f1);
    t1 = c1;
    chk("pre_set_err1", int'(err1), 0);
    clr_err = 1'b1;
    @(posedge clk);
    #1 clr_err = 1'b0;
    chk("set_beats_clear", int'(err1), 1);
    run(3, c1, c4, f1);
    chk("set_clear_hold", int'(err1), 1);
    chk("set_clear_n1", t1 + c1, 0);

    // Partial detent discarded by reset.
    do_reset(1'b0, 1'b0);
    t1 = 0;
    t4 = 0;
    a_in = 1'b1; b_in = 1'b0; run(10, c1, c4, f1); t1 += c1; t4 += c4;
    a_in = 1'b1; b_in = 1'b1; run(10, c1, c4, f1); t1 += c1; t4 += c4;
    a_in = 1'b0; b_in = 1'b1; run(10, c1, c4, f1); t1 += c1; t4 += c4;
    chk("detent3_n1", t1, 3);
    chk("detent3_n4", t4, 0);
    do_reset(1'b0, 1'b1);
    a_in = 1'b0;
    b_in = 1'b0;
    run(10, c1, c4, f1);
    chk("after_rst_n4", c4, 0);
    chk("after_rst_n1", c1, 1);
    chk("after_rst_cw1", int'(cw1), 1);
    chk("after_rst_err4", int'(err4), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
